lfsr_cipher_engine: RTL

- Parametrised LFSR stream-cipher engine that replaces the fixed 6-bit, encrypt-only Lab 4 datapath.
- Talks to an external dat_mem: combinational read, synchronous write.
- Reads pre_len, taps and seed from config words. Then either encrypts (preamble + message) or decrypts (strips and checks preamble, recovers message).
- LFSR width, message length, preamble character and memory map are all parameters.

---
 rtl/lfsr_cipher_engine_if.sv | 28 ++
 rtl/lfsr_cipher_engine.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_cipher_engine_if.sv
// Memory bus between the cipher engine and dat_mem.
// The read path is combinational and the write is synchronous.
interface lfsr_cipher_engine_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  modport master (
    output mem_raddr,
    output mem_we,
    output mem_waddr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_raddr,
    input  mem_we,
    input  mem_waddr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/lfsr_cipher_engine.sv
// Parametrised LFSR stream-cipher engine that encrypts or decrypts
// a preamble plus a message held in dat_mem.
module lfsr_cipher_engine #(
  parameter int             DW       = 8,
  parameter int             AW       = 8,
  parameter int             LW       = 6,
  parameter int             MSG_LEN  = 50,
  parameter logic [DW-1:0]  PRE_CHAR = 'h5F,
  parameter int             PRE_MIN  = 7,
  parameter int             PRE_MAX  = 13,
  parameter int             CFG_BASE = 61,
  parameter int             PT_BASE  = 0,
  parameter int             CT_BASE  = 64
) (
  input  logic                clk,
  input  logic                init,
  input  logic                start,
  input  logic                mode,
  lfsr_cipher_engine_if.master mem,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CW = $clog2(MSG_LEN + PRE_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_LEN,
    S_RD_TAPS,
    S_RD_SEED,
    S_LOAD,
    S_PRE,
    S_MSG,
    S_FIN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic          err_q, err_d;
  logic [DW-1:0] plen_q, plen_d;
  logic [LW-1:0] taps_q, taps_d;
  logic [LW-1:0] seed_q, seed_d;
  logic [LW-1:0] lfsr_q, lfsr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [DW-1:0] key;
  logic [DW-1:0] xdat;
  logic [LW-1:0] lfsr_nxt;
  logic [AW-1:0] plen_a;
  logic [AW-1:0] cnt_a;
  logic          pre_last;
  logic          msg_last;

  assign key      = DW'(lfsr_q);
  assign xdat     = mem.mem_rdata ^ key;
  assign lfsr_nxt = {lfsr_q[LW-2:0], ^(lfsr_q & taps_q)};
  assign plen_a   = AW'(plen_q);
  assign cnt_a    = AW'(cnt_q);
  assign pre_last = (DW'(cnt_q) == plen_q - DW'(1));
  assign msg_last = (cnt_q == CW'(MSG_LEN - 1));
  assign err      = err_q;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    err_d         = err_q;
    plen_d        = plen_q;
    taps_d        = taps_q;
    seed_d        = seed_q;
    lfsr_d        = lfsr_q;
    cnt_d         = cnt_q;
    busy          = 1'b0;
    done          = 1'b0;
    mem.mem_raddr = '0;
    mem.mem_we    = 1'b0;
    mem.mem_waddr = '0;
    mem.mem_wdata = '0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          mode_d  = mode;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RD_LEN;
        end
      end
      S_RD_LEN: begin
        busy          = 1'b1;
        mem.mem_raddr = AW'(CFG_BASE);
        if (mem.mem_rdata < DW'(PRE_MIN))
          plen_d = DW'(PRE_MIN);
        else if (mem.mem_rdata > DW'(PRE_MAX))
          plen_d = DW'(PRE_MAX);
        else
          plen_d = mem.mem_rdata;
        state_d = S_RD_TAPS;
      end
      S_RD_TAPS: begin
        busy          = 1'b1;
        mem.mem_raddr = AW'(CFG_BASE + 1);
        taps_d        = mem.mem_rdata[LW-1:0];
        state_d       = S_RD_SEED;
      end
      S_RD_SEED: begin
        busy          = 1'b1;
        mem.mem_raddr = AW'(CFG_BASE + 2);
        seed_d        = mem.mem_rdata[LW-1:0];
        state_d       = S_LOAD;
      end
      S_LOAD: begin
        busy = 1'b1;
        // An all-zero LFSR or tap set would emit a constant keystream.
        if (taps_q == '0 || seed_q == '0) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          lfsr_d  = seed_q;
          cnt_d   = '0;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        busy   = 1'b1;
        lfsr_d = lfsr_nxt;
        if (!mode_q) begin
          mem.mem_we    = 1'b1;
          mem.mem_waddr = AW'(CT_BASE) + cnt_a;
          mem.mem_wdata = PRE_CHAR ^ key;
        end else begin
          mem.mem_raddr = AW'(CT_BASE) + cnt_a;
          if (xdat != PRE_CHAR)
            err_d = 1'b1;
        end
        if (pre_last) begin
          cnt_d   = '0;
          state_d = S_MSG;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MSG: begin
        busy          = 1'b1;
        lfsr_d        = lfsr_nxt;
        mem.mem_we    = 1'b1;
        mem.mem_wdata = xdat;
        if (!mode_q) begin
          mem.mem_raddr = AW'(PT_BASE) + cnt_a;
          mem.mem_waddr = AW'(CT_BASE) + plen_a + cnt_a;
        end else begin
          mem.mem_raddr = AW'(CT_BASE) + plen_a + cnt_a;
          mem.mem_waddr = AW'(PT_BASE) + cnt_a;
        end
        if (msg_last) begin
          cnt_d   = '0;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIN: begin
        // Wrap-up cycle so done always lands one edge after the last write.
        busy    = 1'b1;
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      plen_q  <= '0;
      taps_q  <= '0;
      seed_q  <= '0;
      lfsr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      plen_q  <= plen_d;
      taps_q  <= taps_d;
      seed_q  <= seed_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
